tick_event_timer: RTL and testbench

Timer stage that consumes the `dividedClk` output of the overflow clock divider and turns it into timed events. It retimes the divided clock, issues a one-`clk`-cycle `tick` on each rising edge, and counts a programmable number of ticks before pulsing `expired`. It runs in one-shot or periodic mode. Everything runs in the `clk` domain; `dividedClk` is used only as data, never as a clock.

---
 rtl/tick_event_timer.sv | 167 ++++++++++++++++
 tb/tb_tick_event_timer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_event_timer.sv
// rtl/tick_event_timer.sv - tick generator and programmable one-shot/periodic event timer
//
// Purpose:
//   Retimes the divided clock (used purely as data), emits a one-cycle tick on
//   each qualified rising edge, and counts a programmable number of ticks
//   before pulsing expired. Supports one-shot and periodic operation with a
//   sticky overrun flag for restarts issued while a run is in progress.
//
// Ports:
//   clk_i          system clock, all state updates on its rising edge
//   reset_ni       asynchronous active-low reset
//   divided_clk_i  divided clock, sampled as a level
//   enable_i       1 = ticks counted, 0 = ticks suppressed, countdown paused
//   start_i        single-cycle load/arm request
//   stop_i         single-cycle abort
//   mode_i         0 = one-shot, 1 = periodic (sampled at load/reload)
//   period_i       ticks per interval (sampled at load/reload)
//   clear_i        clears overrun_o
//   tick_o         one-cycle pulse per qualified rising edge
//   count_o        ticks remaining in the current interval
//   busy_o         high while running
//   expired_o      one-cycle pulse when an interval completes
//   overrun_o      sticky, set by start_i while running

module tick_event_timer #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             reset_ni,
   input  logic             divided_clk_i,
   input  logic             enable_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             mode_i,
   input  logic [WIDTH-1:0] period_i,
   input  logic             clear_i,
   output logic             tick_o,
   output logic [WIDTH-1:0] count_o,
   output logic             busy_o,
   output logic             expired_o,
   output logic             overrun_o
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic             d1_q, d2_q;
   logic             tick_q, tick_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             expired_q, expired_d;
   logic             overrun_q, overrun_d;

   logic             rise;
   logic             count_tick;

   // Two-stage retiming; rise is the sampled 0->1 transition of the divided clock.
   assign rise   = d1_q & ~d2_q;
   // Edges seen while disabled are dropped here rather than remembered.
   assign tick_d = rise & enable_i;

   // A tick already registered when enable drops is not counted either, so
   // the countdown freezes on the very cycle enable goes low.
   assign count_tick = tick_q & enable_i;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         d1_q   <= 1'b0;
         d2_q   <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         d1_q   <= divided_clk_i;
         d2_q   <= d1_q;
         tick_q <= tick_d;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         mode_q    <= 1'b0;
         period_q  <= '0;
         expired_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         mode_q    <= mode_d;
         period_q  <= period_d;
         expired_q <= expired_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      mode_d    = mode_q;
      period_d  = period_q;
      expired_d = 1'b0;
      overrun_d = overrun_q;

      // Clear is applied first so a simultaneous restart below can override it.
      if (clear_i) begin
         overrun_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (start_i && (period_i != '0)) begin
               count_d  = period_i;
               mode_d   = mode_i;
               period_d = period_i;
               state_d  = ST_RUN;
            end
         end

         ST_RUN: begin
            if (stop_i) begin
               count_d = '0;
               state_d = ST_IDLE;
            end else if (start_i) begin
               overrun_d = 1'b1;
               mode_d    = mode_i;
               period_d  = period_i;
               if (period_i == '0) begin
                  count_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  count_d = period_i;
               end
            end else if (count_tick) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (count_q == WIDTH'(1)) begin
                  expired_d = 1'b1;
                  if (mode_q) begin
                     count_d = period_q;
                  end else begin
                     count_d = '0;
                     state_d = ST_IDLE;
                  end
               end
               // count_q == 0 cannot occur while running; never decrement it.
            end
         end

         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   assign tick_o    = tick_q;
   assign count_o   = count_q;
   assign busy_o    = (state_q == ST_RUN);
   assign expired_o = expired_q;
   assign overrun_o = overrun_q;

endmodule

// File: tb/tb_tick_event_timer.sv
// tb/tb_tick_event_timer.sv - directed self-checking bench for tick_event_timer

module tb_tick_event_timer;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             dc;
   logic             enable;
   logic             start;
   logic             stop;
   logic             mode;
   logic [WIDTH-1:0] period;
   logic             clear;
   logic             tick;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             expired;
   logic             overrun;

   int passed = 0;
   int total  = 0;

   tick_event_timer #(.WIDTH(WIDTH)) dut (
      .clk_i        (clk),
      .reset_ni     (reset_n),
      .divided_clk_i(dc),
      .enable_i     (enable),
      .start_i      (start),
      .stop_i       (stop),
      .mode_i       (mode),
      .period_i     (period),
      .clear_i      (clear),
      .tick_o       (tick),
      .count_o      (count),
      .busy_o       (busy),
      .expired_o    (expired),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " tick"},    32'(tick),    0);
      check({tag, " count"},   32'(count),   0);
      check({tag, " busy"},    32'(busy),    0);
      check({tag, " expired"}, 32'(expired), 0);
      check({tag, " overrun"}, 32'(overrun), 0);
   endtask

   // One divided-clock period of 10 cycles (5 high, 5 low). Edge E is the first
   // step; tick is visible after E+1, count/expired/busy after E+2.
   task automatic dc_pulse(input string tag, input logic exp_tick,
                           input int exp_cnt, input logic exp_exp, input logic exp_busy);
      dc = 1'b1;
      step();
      check({tag, " tick pre"}, 32'(tick), 0);
      step();
      check({tag, " tick"}, 32'(tick), 32'(exp_tick));
      step();
      check({tag, " tick width"}, 32'(tick), 0);
      check({tag, " count"}, 32'(count), 32'(exp_cnt));
      check({tag, " expired"}, 32'(expired), 32'(exp_exp));
      check({tag, " busy"}, 32'(busy), 32'(exp_busy));
      step();
      check({tag, " expired width"}, 32'(expired), 0);
      step();
      dc = 1'b0;
      repeat (5) step();
   endtask

   initial begin
      reset_n = 1'b0;
      dc      = 1'b0;
      enable  = 1'b1;
      start   = 1'b0;
      stop    = 1'b0;
      mode    = 1'b0;
      period  = '0;
      clear   = 1'b0;

      // Reset held while the divided clock toggles.
      step();
      check_quiet("rst c1");
      dc = 1'b1;
      step();
      check_quiet("rst c2");
      step();
      check_quiet("rst c3");
      dc = 1'b0;
      reset_n = 1'b1;
      step();
      step();
      check_quiet("post rst");
      dc = 1'b1;
      step();
      check("rst E tick", 32'(tick), 0);
      step();
      check("rst E+1 tick", 32'(tick), 1);
      check("rst idle count", 32'(count), 0);
      step();
      check("rst E+2 tick", 32'(tick), 0);
      check("rst idle busy", 32'(busy), 0);
      step();
      step();
      dc = 1'b0;
      repeat (5) step();

      // One-shot, period 3.
      mode   = 1'b0;
      period = 16'd3;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("os load busy", 32'(busy), 1);
      check("os load count", 32'(count), 3);
      dc_pulse("os t1", 1'b1, 2, 1'b0, 1'b1);
      dc_pulse("os t2", 1'b1, 1, 1'b0, 1'b1);
      dc_pulse("os t3", 1'b1, 0, 1'b1, 1'b0);
      dc_pulse("os after", 1'b1, 0, 1'b0, 1'b0);

      // Periodic, period 2.
      mode   = 1'b1;
      period = 16'd2;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("per load count", 32'(count), 2);
      check("per load busy", 32'(busy), 1);
      dc_pulse("per t1", 1'b1, 1, 1'b0, 1'b1);
      dc_pulse("per t2", 1'b1, 2, 1'b1, 1'b1);
      dc_pulse("per t3", 1'b1, 1, 1'b0, 1'b1);
      dc_pulse("per t4", 1'b1, 2, 1'b1, 1'b1);

      // Pause for 25 cycles at count 2; edges during the pause are lost.
      enable = 1'b0;
      dc_pulse("pause p1", 1'b0, 2, 1'b0, 1'b1);
      dc_pulse("pause p2", 1'b0, 2, 1'b0, 1'b1);
      repeat (5) step();
      check("pause hold count", 32'(count), 2);
      enable = 1'b1;
      dc_pulse("resume", 1'b1, 1, 1'b0, 1'b1);

      // Restart with period 5 at count 1 on the same edge a tick is consumed.
      dc = 1'b1;
      step();
      step();
      check("rs tick high", 32'(tick), 1);
      check("rs count 1", 32'(count), 1);
      start  = 1'b1;
      period = 16'd5;
      step();
      start = 1'b0;
      check("rs count", 32'(count), 5);
      check("rs overrun", 32'(overrun), 1);
      check("rs no expired", 32'(expired), 0);
      check("rs busy", 32'(busy), 1);
      step();
      check("rs no expired late", 32'(expired), 0);
      dc = 1'b0;
      repeat (5) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear overrun", 32'(overrun), 0);
      check("clear keeps count", 32'(count), 5);

      // Clear and restart in the same cycle: set wins.
      clear  = 1'b1;
      start  = 1'b1;
      period = 16'd4;
      step();
      clear = 1'b0;
      start = 1'b0;
      check("clr+start overrun", 32'(overrun), 1);
      check("clr+start count", 32'(count), 4);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("clear2 overrun", 32'(overrun), 0);

      // Stop beats start while running.
      stop   = 1'b1;
      start  = 1'b1;
      period = 16'd7;
      step();
      stop  = 1'b0;
      start = 1'b0;
      check("abort busy", 32'(busy), 0);
      check("abort count", 32'(count), 0);
      check("abort expired", 32'(expired), 0);
      check("abort overrun", 32'(overrun), 0);
      step();
      check("abort expired late", 32'(expired), 0);

      // Zero period start from idle is ignored.
      period = '0;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("zero busy", 32'(busy), 0);
      check("zero count", 32'(count), 0);
      dc_pulse("zero idle", 1'b1, 0, 1'b0, 1'b0);

      // Restart with period 0 while running drops to idle and flags overrun.
      mode   = 1'b0;
      period = 16'd3;
      start  = 1'b1;
      step();
      period = '0;
      step();
      start = 1'b0;
      check("rs0 busy", 32'(busy), 0);
      check("rs0 count", 32'(count), 0);
      check("rs0 overrun", 32'(overrun), 1);

      // Reset mid-run returns to idle without an expired pulse.
      period = 16'd1;
      start  = 1'b1;
      step();
      start = 1'b0;
      check("mid load busy", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("mid rst busy", 32'(busy), 0);
      check("mid rst count", 32'(count), 0);
      check("mid rst overrun", 32'(overrun), 0);
      step();
      check("mid rst expired", 32'(expired), 0);
      reset_n = 1'b1;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
